alu_ctrl: RTL

Multi-cycle execution sequencer that drives the 32-bit ALU from the issuing side.
- Accepts one instruction word per valid/ready handshake and decodes it.
- Reads source operands from an external synchronous register file, presents them and the 5-bit operation code to the ALU, and captures `out_bus` and the Z/N/C/V flags.
- Writes the result back and keeps an architectural flags register used for conditional execution.
- Sits between instruction fetch and the ALU/register-file datapath.

---
 rtl/alu_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: four-state execution sequencer (IDLE -> READ -> EXEC -> WB).
// Accepts one instruction per valid/ready handshake and reads both operands
// from a synchronous register file. It drives the ALU, then writes the result
// back and updates the architectural {Z,N,C,V} flags when the condition passes.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN.
//   Defined:   an illegal opcode sets the sticky err bit, suppresses done and
//              stops accepting instructions until reset.
//   Undefined: an illegal opcode retires like a NOP and err is tied to 0.
module alu_ctrl #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic [3:0]  flags,
    output logic        done,
    output logic        err
);

    localparam int DATA_W = 32;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_LD  = 5'h01;
    localparam logic [4:0] OP_ADD = 5'h03;
    localparam logic [4:0] OP_SUB = 5'h04;
    localparam logic [4:0] OP_AND = 5'h05;
    localparam logic [4:0] OP_OR  = 5'h06;
    localparam logic [4:0] OP_XOR = 5'h07;
    localparam logic [4:0] OP_NOT = 5'h08;
    localparam logic [4:0] OP_SL  = 5'h09;
    localparam logic [4:0] OP_SR  = 5'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Instruction word held for the whole sequence; bits [11:0] carry nothing.
    logic [31:12]      instr_p0;
    // Values captured at the end of EXEC and consumed in WB.
    logic [DATA_W-1:0] result_p1;
    logic [3:0]        aflags_p1;
    logic              cond_ok_p1;

    logic [4:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [2:0] cond;
    logic       wb_commit;
    logic       trap_wb;
    logic       unused_instr_lsbs;

    assign op   = instr_p0[31:27];
    assign rd   = instr_p0[26:23];
    assign rs1  = instr_p0[22:19];
    assign rs2  = instr_p0[18:15];
    assign cond = instr_p0[14:12];

    assign unused_instr_lsbs = ^instr[11:0];

    function automatic logic op_legal(input logic [4:0] o);
        case (o)
            OP_NOP, OP_LD, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_NOT, OP_SL, OP_SR: op_legal = 1'b1;
            default:                             op_legal = 1'b0;
        endcase
    endfunction

    // Condition check against the architectural flags {Z,N,C,V}.
    function automatic logic cond_pass(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0:    cond_pass = 1'b1;
            3'd1:    cond_pass = f[3];
            3'd2:    cond_pass = ~f[3];
            3'd3:    cond_pass = f[2];
            3'd4:    cond_pass = f[1];
            3'd5:    cond_pass = f[0];
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Chooses which ALU flags an op may change; masked flags are cleared.
    function automatic logic [3:0] flag_update(input logic [4:0] o, input logic [3:0] af);
        case (o)
            OP_ADD, OP_SL: flag_update = af;
            OP_SUB:        flag_update = {af[3], af[2], 1'b0, af[0]};
            default:       flag_update = {af[3], af[2], 2'b00};
        endcase
    endfunction

    assign wb_commit = op_legal(op) && (op != OP_NOP) && cond_ok_p1;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    assign trap_wb = (state == WB) && !op_legal(op);

    // Sticky trap indication; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       err <= 1'b0;
        else if (trap_wb) err <= 1'b1;
    end
`else
    assign trap_wb = 1'b0;
    assign err     = 1'b0;
`endif

    // State register; reset drops any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and all sequencer outputs, decoded from the current state.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        rf_raddr_a  = '0;
        rf_raddr_b  = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = OP_NOP;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = ~err;
                if (instr_valid && !err) state_nxt = READ;
            end
            READ: begin
                rf_raddr_a = rs1;
                rf_raddr_b = rs2;
                state_nxt  = EXEC;
            end
            EXEC: begin
                alu_a     = rf_rdata_a;
                alu_b     = rf_rdata_b;
                alu_op    = op;
                state_nxt = WB;
            end
            WB: begin
                rf_waddr  = rd;
                rf_wdata  = result_p1;
                rf_we     = wb_commit;
                done      = ~trap_wb;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p0: instruction capture on handshake ----
    always_ff @(posedge clk) begin
        if (instr_valid && instr_ready) instr_p0 <= instr[31:12];
    end

    // ---- stage p1: ALU result, ALU flags and condition outcome ----
    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            result_p1  <= alu_result;
            aflags_p1  <= {alu_z, alu_n, alu_c, alu_v};
            cond_ok_p1 <= cond_pass(cond, flags);
        end
    end

    // Architectural flags change only when the instruction commits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         flags <= FLAGS_RESET;
        else if (state == WB && wb_commit)  flags <= flag_update(op, aflags_p1);
    end

endmodule
